instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decode/control stage. Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers returned instructions in a small FIFO. Presents {pc, instr, opcode} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, maximum of (outstanding requests + buffered entries); legal values 1..4.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address (bits[1:0]=0).
- imem_rsp_valid  input  1  response valid; in order; at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_pc  input  32  new PC; bits[1:0] ignored, forced to 0.
- id_valid  output  1  instruction available to decode.
- id_ready  input  1  decode accepts (0 = hazard stall).
- id_pc  output  32  PC of presented instruction.
- id_instr  output  32  presented instruction.
- id_opcode  output  7  id_instr[6:0]; drives control-unit opcode.
- id_illegal  output  1  unsupported opcode flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=BOOT. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_pc=0, id_instr=0, id_opcode=0, id_illegal=0.
- States:
  - BOOT: one cycle, no request; always goes to RUN.
  - RUN: normal fetch.
  - DRAIN: discard>0 after a redirect.
- Transitions:
  - RUN->DRAIN on redirect_valid with responses still in flight.
  - DRAIN->RUN when discard reaches 0.
  - Redirect in DRAIN reloads discard with the current in-flight count and stays in DRAIN.
- Request issue:
  - imem_req_valid=1 in RUN and DRAIN when outstanding + fifo_count < DEPTH and redirect_valid=0.
  - imem_req_addr=pc.
  - On acceptance (valid&&ready): pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), outstanding += 1.
  - Request stays stable while ready=0.
- Response, discard>0: dropped; discard -= 1, outstanding -= 1.
- Response, discard=0: pushed {pc_tag, data}; outstanding -= 1. pc_tag comes from an internal tag FIFO of issued addresses. Push never overflows, guaranteed by the credit rule.
- Decode side:
  - id_valid = FIFO non-empty and redirect_valid=0.
  - Pop on id_valid&&id_ready. id_* show the FIFO head, combinationally from the FIFO.
  - Zero-latency bypass is not used: min latency from request acceptance to id_valid is rsp latency + 1 cycle (response registered into FIFO).
- Redirect, same cycle:
  - FIFO flushed, pc=redirect_pc.
  - discard = outstanding, minus 1 if a response arrives that same cycle (that response is dropped).
  - No request issued, no pop.
  - Next cycle: request to redirect_pc if credit allows.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- id_ready=0 holds id_* stable. Fetch continues until credits are exhausted, then imem_req_valid=0.
- Mid-operation reset: all in-flight state cleared. Late responses after reset release are an environment error, not handled.

Optional Feature:
- Macro IFU_OPCODE_CHECK_EN.
- Defined: id_illegal = id_valid and id_opcode not in {0110011, 0000011, 0010011, 1100111, 0100011, 1100011, 0010111, 0110111, 1101111, 1010011, 0000111, 0100111}. Flag only; the instruction is still delivered.
- Undefined: id_illegal tied 0. Port always present.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle rsp latency, id_ready=1: addresses 0x0,0x4,0x8 issued on consecutive cycles after BOOT. First id_valid has id_pc=0x0 and id_instr equal to the returned word.
- id_ready=0 for 10 cycles with DEPTH=2: at most 2 requests outstanding or buffered, then imem_req_valid=0. id_pc holds 0x0 throughout. Release gives in-order pops of 0x0, 0x4.
- Redirect to 0x100 with 2 responses in flight: both dropped (never on id_*), state DRAIN. Next accepted request addr=0x100, first id_pc=0x100.
- imem_req_ready=0 for 5 cycles: imem_req_addr stable at the current pc and pc does not advance. Acceptance on the 6th cycle increments pc by 4.
- RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap). Redirect_pc=0x103 yields addr 0x100.
- With IFU_OPCODE_CHECK_EN: instr 32'h0000_007F gives id_illegal=1; 32'h0000_0033 gives id_illegal=0. Without the macro, both give id_illegal=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage in front of decode. It owns the PC, issues in-order
//            word requests to instruction memory, buffers the returned words
//            in a small FIFO and presents {pc, instr, opcode} to decode.
//            A branch/jump redirect flushes the FIFO and discards responses
//            that are still in flight.
// Ports    : clk, rst_n                        clock, async active-low reset
//            imem_req_valid/ready/addr         request channel (valid/ready)
//            imem_rsp_valid/data               response channel (valid only)
//            redirect_valid/pc                 branch/jump redirect pulse
//            id_valid/ready/pc/instr/opcode    decode handshake and payload
//            id_illegal                        unsupported-opcode flag
// Params   : RESET_PC  first fetch address after reset
//            DEPTH     limit on outstanding requests + buffered words (1..4)
// Options  : IFU_OPCODE_CHECK_EN  when defined, id_illegal flags opcodes
//            outside the supported set; otherwise id_illegal is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  id_opcode,
  output logic        id_illegal
);

  // Storage is rounded up to a power of two; pointers wrap at DEPTH-1.
  localparam int              c_PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_SLOTS    = 1 << c_PW;
  localparam logic [c_PW-1:0] c_LAST     = c_PW'(DEPTH - 1);
  localparam logic [2:0]      c_DEPTH    = 3'(DEPTH);
  localparam logic [31:0]     c_RESET_PC = {RESET_PC[31:2], 2'b00};

  localparam logic [1:0] c_BOOT  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [31:0]     r_pc;
  logic [2:0]      r_outstanding;
  logic [2:0]      r_discard;

  // Tag FIFO: addresses of issued requests, popped by every response.
  logic [31:0]     r_tag [c_SLOTS];
  logic [c_PW-1:0] r_tag_wr;
  logic [c_PW-1:0] r_tag_rd;

  // Instruction FIFO towards decode.
  logic [31:0]     r_fifo_pc    [c_SLOTS];
  logic [31:0]     r_fifo_instr [c_SLOTS];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [2:0]      r_count;

  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_drop_std;
  logic            w_push;
  logic            w_id_valid;
  logic            w_pop;
  logic [2:0]      w_inflight;
  logic [31:0]     w_head_instr;
  logic            w_unused_bits;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    if (p == c_LAST) return '0;
    return p + 1'b1;
  endfunction

  // Credit counts both in-flight requests and words already buffered, so a
  // response can always be pushed without overflow.
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_count}) < {1'b0, c_DEPTH};
  assign w_req_valid = (r_state != c_BOOT) && w_credit && !redirect_valid;
  assign w_req_fire  = w_req_valid && imem_req_ready;

  // A response is dropped while discards are pending or when it coincides
  // with a redirect; otherwise it is buffered.
  assign w_drop_std  = imem_rsp_valid && (r_discard != 3'd0);
  assign w_push      = imem_rsp_valid && (r_discard == 3'd0) && !redirect_valid;

  assign w_id_valid  = (r_count != 3'd0) && !redirect_valid;
  assign w_pop       = w_id_valid && id_ready;

  // Requests still owed a response after this cycle's response (if any).
  assign w_inflight  = r_outstanding - 3'(imem_rsp_valid);

  // Low bits of the redirect target are ignored; the PC is forced aligned.
  assign w_unused_bits = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_BOOT:  w_state_nxt = c_RUN;
      c_RUN:   if (redirect_valid && (w_inflight != 3'd0)) w_state_nxt = c_DRAIN;
      c_DRAIN: if (!redirect_valid &&
                   ((r_discard == 3'd0) || (w_drop_std && (r_discard == 3'd1))))
                 w_state_nxt = c_RUN;
      default: w_state_nxt = c_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_BOOT;
      r_pc          <= c_RESET_PC;
      r_outstanding <= 3'd0;
      r_discard     <= 3'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + 3'(w_req_fire) - 3'(imem_rsp_valid);
      if (redirect_valid) begin
        r_pc      <= {redirect_pc[31:2], 2'b00};
        r_discard <= w_inflight;
      end else begin
        if (w_req_fire) r_pc <= r_pc + 32'd4;
        if (w_drop_std) r_discard <= r_discard - 3'd1;
      end
    end
  end

  // Tag FIFO is not flushed on redirect: discarded responses still consume
  // their tags so later tags stay aligned with later responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_SLOTS; i++) r_tag[i] <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_req_fire) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= f_next(r_tag_wr);
      end
      if (imem_rsp_valid) r_tag_rd <= f_next(r_tag_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_SLOTS; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
        r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        r_wr_ptr               <= f_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

  assign w_head_instr   = r_fifo_instr[r_rd_ptr];
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = w_id_valid;
  assign id_pc          = r_fifo_pc[r_rd_ptr];
  assign id_instr       = w_head_instr;
  assign id_opcode      = w_head_instr[6:0];

`ifdef IFU_OPCODE_CHECK_EN
  logic w_opcode_ok;

  always_comb begin
    w_opcode_ok = 1'b0;
    case (w_head_instr[6:0])
      7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
      7'b0100011, 7'b1100011, 7'b0010111, 7'b0110111,
      7'b1101111, 7'b1010011, 7'b0000111, 7'b0100111: w_opcode_ok = 1'b1;
      default:                                        w_opcode_ok = 1'b0;
    endcase
  end

  assign id_illegal = w_id_valid && !w_opcode_ok;
`else
  assign id_illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit (RESET_PC=0, DEPTH=2).
//            A cycle table with hand-computed outputs covers boot, fetch,
//            stall and redirect; scripted sequences with a small memory
//            model cover the multi-cycle corner cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic        id_illegal;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .id_opcode(id_opcode), .id_illegal(id_illegal)
  );

  // Response source: table-driven or memory model.
  logic        mem_en;
  logic        m_rv, tbl_rv;
  logic [31:0] m_rd, tbl_rd;
  assign imem_rsp_valid = mem_en ? m_rv : tbl_rv;
  assign imem_rsp_data  = mem_en ? m_rd : tbl_rd;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        idr;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_idv;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] acc[$];
  logic [31:0] pops[$];
  vec_t        vecs[17];
  int          cyc;
  int          lat;
  int          tests = 0;
  int          fails = 0;

  localparam logic [31:0] D0 = 32'hA000_0013, D1 = 32'hA000_1013, D2 = 32'hA000_2013;
  localparam logic [31:0] D3 = 32'hA000_3013, D4 = 32'hA000_4013, D5 = 32'hA000_5013;
  localparam logic [31:0] D6 = 32'hA000_6013;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_007F;
    if (a == 32'h0000_0204) return 32'h0000_0033;
    return {a[26:2], 7'h13};
  endfunction

`ifdef IFU_OPCODE_CHECK_EN
  function automatic logic tb_legal(input logic [6:0] op);
    case (op)
      7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
      7'h17, 7'h37, 7'h6F, 7'h53, 7'h07, 7'h27: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc.size()) return acc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (i < pops.size()) return pops[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs applied at the falling edge, outputs observed 1ns later.
  task automatic step(input logic ready, input logic redir, input logic [31:0] rpc,
                      input logic idr, input logic tv, input logic [31:0] td);
    logic [31:0] w;
    logic        exp_ill;
    @(negedge clk);
    cyc++;
    imem_req_ready = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = idr;
    tbl_rv         = tv;
    tbl_rd         = td;
    m_rv           = 1'b0;
    if (mem_en && (mq.size() > 0) && (mq[0].due <= cyc)) begin
      m_rv = 1'b1;
      m_rd = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    if (mem_en) begin
      if (imem_req_valid && imem_req_ready) begin
        acc.push_back(imem_req_addr);
        mq.push_back('{imem_req_addr, cyc + lat});
      end
      if (id_valid && id_ready) begin
        pops.push_back(id_pc);
        w = mem_word(id_pc);
        check("pop instr", id_instr, w);
        check("pop opcode", {25'd0, id_opcode}, {25'd0, w[6:0]});
`ifdef IFU_OPCODE_CHECK_EN
        exp_ill = !tb_legal(w[6:0]);
`else
        exp_ill = 1'b0;
`endif
        check("pop illegal", {31'd0, id_illegal}, {31'd0, exp_ill});
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    tbl_rv         = 1'b0;
    tbl_rd         = 32'h0;
    m_rv           = 1'b0;
    m_rd           = 32'h0;
    mq.delete();
    acc.delete();
    pops.delete();
    repeat (2) @(negedge clk);
    #1;
    check({tag, " rst req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, " rst req_addr"}, imem_req_addr, 32'h0);
    check({tag, " rst id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, " rst id_pc"}, id_pc, 32'h0);
    check({tag, " rst id_instr"}, id_instr, 32'h0);
    check({tag, " rst id_opcode"}, {25'd0, id_opcode}, 32'd0);
    check({tag, " rst id_illegal"}, {31'd0, id_illegal}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    mem_en = 1'b0;
    lat    = 1;
    //          ready rv  rd  redir rpc         idr | rv  addr          idv pc            instr
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,   32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,   32'h0};
    vecs[2]  = '{1'b1, 1'b1, D0,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0,   32'h0};
    vecs[3]  = '{1'b1, 1'b1, D1,    1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0,   D0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h4,   D1};
    vecs[5]  = '{1'b1, 1'b1, D2,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0,   32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h8,   D2};
    vecs[7]  = '{1'b1, 1'b1, D3,    1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h8,   D2};
    vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0000_0010, 1'b1, 32'h8,   D2};
    vecs[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h8,   D2};
    vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'hC,   D3};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0000_0014, 1'b0, 32'h0,   32'h0};
    vecs[12] = '{1'b1, 1'b1, D4,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,   32'h0};
    vecs[13] = '{1'b0, 1'b1, D5,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0,   32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b1, 32'h100, D5};
    vecs[15] = '{1'b0, 1'b1, D6,    1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0108, 1'b0, 32'h0,   32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0108, 1'b1, 32'h104, D6};

    // ---- Table: boot, fetch, decode stall, redirect with a drop ----
    do_reset("tbl");
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].ready, vecs[i].redir, vecs[i].rpc, vecs[i].idr, vecs[i].rv, vecs[i].rd);
      check($sformatf("row%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].exp_rv});
      check($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("row%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_idv});
      if (vecs[i].exp_idv) begin
        check($sformatf("row%0d id_pc", i), id_pc, vecs[i].exp_pc);
        check($sformatf("row%0d id_instr", i), id_instr, vecs[i].exp_instr);
        check($sformatf("row%0d id_opcode", i), {25'd0, id_opcode}, {25'd0, vecs[i].exp_instr[6:0]});
        check($sformatf("row%0d id_illegal", i), {31'd0, id_illegal}, 32'd0);
      end
    end

    // ---- Mid-operation reset (FIFO holds an entry), then decode stall ----
    do_reset("stall");
    mem_en = 1'b1;
    lat    = 1;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      if (id_valid) check("stall id_pc", id_pc, 32'h0);
    end
    check("stall accepted count", acc.size(), 32'd2);
    check("stall req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("stall id_valid", {31'd0, id_valid}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("stall pop0", pop_at(0), 32'h0);
    check("stall pop1", pop_at(1), 32'h4);
    check("stall pop2", pop_at(2), 32'h8);

    // ---- Redirect with two responses in flight ----
    do_reset("drain");
    mem_en = 1'b1;
    lat    = 3;
    for (int i = 0; i < 10 && acc.size() < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("drain two in flight", acc.size(), 32'd2);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    check("drain redirect req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("drain redirect id_valid", {31'd0, id_valid}, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("drain next req addr", acc_at(2), 32'h100);
    check("drain first id_pc", pop_at(0), 32'h100);
    check("drain second id_pc", pop_at(1), 32'h104);

    // ---- Redirect coinciding with a response; opcode flag ----
    do_reset("coinc");
    mem_en = 1'b1;
    lat    = 2;
    for (int i = 0; i < 10 && acc.size() < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("coinc first id_pc", pop_at(0), 32'h200);
    check("coinc second id_pc", pop_at(1), 32'h204);

    // ---- Memory back-pressure: request held stable ----
    do_reset("bp");
    mem_en = 1'b1;
    lat    = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      check($sformatf("bp cyc%0d req_valid", i), {31'd0, imem_req_valid}, 32'd1);
      check($sformatf("bp cyc%0d req_addr", i), imem_req_addr, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("bp accept addr", imem_req_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("bp next addr", imem_req_addr, 32'h4);

    // ---- Address wrap at the top of the address space ----
    do_reset("wrap");
    mem_en = 1'b1;
    lat    = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check("wrap acc0", acc_at(0), 32'hFFFF_FFF8);
    check("wrap acc1", acc_at(1), 32'hFFFF_FFFC);
    check("wrap acc2", acc_at(2), 32'h0000_0000);
    check("wrap pop0", pop_at(0), 32'hFFFF_FFF8);
    check("wrap pop1", pop_at(1), 32'hFFFF_FFFC);
    check("wrap pop2", pop_at(2), 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
